// File: rtl/conv_pkg.sv
// Shared defaults for the convolution accumulation stage.
// Holds the width constants, the tap count, the shift amount and a counter-width helper.
package conv_pkg;

    localparam int DATA_W     = 16;
    localparam int ACC_W      = 32;
    localparam int OUT_W      = 16;
    localparam int TAPS       = 9;
    localparam int FRAC_SHIFT = 8;

    // A single-tap window still needs a one-bit counter to keep the logic uniform.
    function automatic int cnt_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/conv_sat.sv
// Combinational post-processing of a window total: arithmetic shift, saturate, optional ReLU.
// Build option: define CONV_ACCUM_RELU_EN to clamp negative results to zero.
module conv_sat #(
    parameter int ACC_W      = conv_pkg::ACC_W,
    parameter int OUT_W      = conv_pkg::OUT_W,
    parameter int FRAC_SHIFT = conv_pkg::FRAC_SHIFT
) (
    input  logic signed [ACC_W:0]   total_i,
    output logic signed [OUT_W-1:0] res_o,
    output logic                    ovf_o
);

    logic signed [ACC_W:0]       shifted;
    logic [ACC_W-OUT_W+1:0]      upper;
    logic                        in_range;
    logic signed [OUT_W-1:0]     sat;

    always_comb begin
        shifted  = total_i >>> FRAC_SHIFT;
        // The value fits when every bit above the output sign bit matches it.
        upper    = shifted[ACC_W:OUT_W-1];
        in_range = (&upper) || (~|upper);
        sat      = shifted[OUT_W-1:0];
        ovf_o    = 1'b0;
        if (!in_range) begin
            ovf_o = 1'b1;
            if (shifted[ACC_W]) begin
                sat = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                sat = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
`ifdef CONV_ACCUM_RELU_EN
        res_o = sat[OUT_W-1] ? '0 : sat;
`else
        res_o = sat;
`endif
    end

endmodule

// File: rtl/conv_accum.sv
// Window accumulator: sums TAPS signed partial results, adds a per-window bias and emits a
// shifted, saturated result over a valid/ready output register (CONV_ACCUM_RELU_EN selects ReLU).
module conv_accum #(
    parameter int DATA_W     = conv_pkg::DATA_W,
    parameter int ACC_W      = conv_pkg::ACC_W,
    parameter int OUT_W      = conv_pkg::OUT_W,
    parameter int TAPS       = conv_pkg::TAPS,
    parameter int FRAC_SHIFT = conv_pkg::FRAC_SHIFT
) (
    input  logic                     clock,
    input  logic                     aclr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [ACC_W-1:0]  bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_ovf,
    output logic                     busy
);

    localparam int              CNT_W    = conv_pkg::cnt_width(TAPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  bias_q, bias_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;
    logic                     out_ovf_q, out_ovf_d;

    logic                     first_tap;
    logic                     last_tap;
    logic                     accept;
    logic signed [ACC_W-1:0]  in_ext;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  bias_sel;
    logic signed [ACC_W:0]    total;
    logic signed [OUT_W-1:0]  sat_res;
    logic                     sat_ovf;

    always_comb begin
        first_tap = (cnt_q == '0);
        last_tap  = (cnt_q == LAST_CNT);
        // Stall only a closing tap whose result would overwrite an unconsumed one.
        in_ready  = !aclr && !(last_tap && out_valid_q && !out_ready);
        accept    = in_valid && in_ready;
        in_ext    = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
        // With a single-tap window the first tap is also the last: no history, live bias.
        acc_base  = first_tap ? '0 : acc_q;
        bias_sel  = first_tap ? bias : bias_q;
        total     = {acc_base[ACC_W-1], acc_base}
                  + {in_ext[ACC_W-1], in_ext}
                  + {bias_sel[ACC_W-1], bias_sel};
    end

    conv_sat #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_sat (
        .total_i (total),
        .res_o   (sat_res),
        .ovf_o   (sat_ovf)
    );

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        bias_d      = bias_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (last_tap) begin
                out_data_d  = sat_res;
                out_ovf_d   = sat_ovf;
                out_valid_d = 1'b1;
                cnt_d       = '0;
            end else if (first_tap) begin
                acc_d  = in_ext;
                bias_d = bias;
                cnt_d  = cnt_q + CNT_W'(1);
            end else begin
                acc_d = acc_q + in_ext;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            bias_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_conv_accum.sv
// Bench for conv_accum: directed windows checked against a queue-based window model every cycle,
// plus literal expectations for the hand-computed scenarios.
module tb_conv_accum;

    localparam int DATA_W     = 16;
    localparam int ACC_W      = 32;
    localparam int OUT_W      = 16;
    localparam int TAPS       = 9;
    localparam int FRAC_SHIFT = 8;

    logic                     clock = 1'b0;
    logic                     aclr;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic signed [ACC_W-1:0]  bias;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_ovf;
    logic                     busy;

    conv_accum #(
        .DATA_W     (DATA_W),
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .TAPS       (TAPS),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) dut (
        .clock     (clock),
        .aclr      (aclr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        longint data;
        bit     ovf;
    } res_t;

    longint win[$];
    longint win_bias;
    res_t   expq[$];
    bit     rst_prev    = 1'b0;
    int     valid_cycles = 0;
    int     n_results   = 0;
    longint last_data   = 0;
    longint last_ovf    = 0;

    function automatic longint wrapw(input longint v, input int w);
        longint m;
        m = v & ((64'sd1 <<< w) - 1);
        if (m[w-1]) m = m - (64'sd1 <<< w);
        return m;
    endfunction

    function automatic res_t window_result();
        res_t   r;
        longint acc;
        longint t;
        longint s;
        acc = 0;
        for (int i = 0; i < TAPS - 1; i++) acc = wrapw(acc + win[i], ACC_W);
        t = wrapw(acc + win[TAPS-1] + win_bias, ACC_W + 1);
        s = t >>> FRAC_SHIFT;
        r.ovf = 1'b0;
        if (s > 32767) begin
            s = 32767;
            r.ovf = 1'b1;
        end else if (s < -32768) begin
            s = -32768;
            r.ovf = 1'b1;
        end
`ifdef CONV_ACCUM_RELU_EN
        if (s < 0) s = 0;
`endif
        r.data = s;
        return r;
    endfunction

    // Mid-cycle compare against the model, then advance the model by this cycle's events.
    always @(negedge clock) begin
        bit exp_ready;
        res_t r;
        if (rst_prev) begin
            check("rst_out_data", longint'(out_data), 0);
            check("rst_out_ovf", longint'(out_ovf), 0);
            check("rst_busy", longint'(busy), 0);
        end
        exp_ready = !aclr && !(win.size() == TAPS - 1 && expq.size() != 0 && !out_ready);
        check("in_ready", longint'(in_ready), longint'(exp_ready));
        check("out_valid", longint'(out_valid), longint'(expq.size() != 0));
        check("busy", longint'(busy), longint'(win.size() != 0));
        if (out_valid && expq.size() != 0) begin
            check("out_data", longint'(out_data), expq[0].data);
            check("out_ovf", longint'(out_ovf), longint'(expq[0].ovf));
        end
        if (out_valid) valid_cycles++;
        if (out_valid && out_ready && expq.size() != 0) begin
            last_data = longint'(out_data);
            last_ovf  = longint'(out_ovf);
            n_results++;
            void'(expq.pop_front());
        end
        if (aclr) begin
            win.delete();
            expq.delete();
        end else if (in_valid && in_ready) begin
            if (win.size() == 0) win_bias = longint'(bias);
            win.push_back(longint'(in_data));
            if (win.size() == TAPS) begin
                r = window_result();
                expq.push_back(r);
                win.delete();
            end
        end
        rst_prev = aclr;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic send_tap(input longint d, input longint b);
        bit acc_ok;
        acc_ok   = 1'b0;
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        bias     = ACC_W'(b);
        for (int c = 0; c < 50 && !acc_ok; c++) begin
            @(negedge clock);
            acc_ok = in_ready;
            tick();
        end
        if (!acc_ok) check("tap_timeout", 0, 1);
    endtask

    task automatic send_window(input longint d, input longint b, input int n);
        for (int i = 0; i < n; i++) send_tap(d, b);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            tick();
            done = (expq.size() == 0) && !out_valid;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    task automatic run_case(input string name, input longint d, input longint b,
                            input longint exp_d, input longint exp_o);
        send_window(d, b, TAPS);
        drain();
        check({name, "_data"}, last_data, exp_d);
        check({name, "_ovf"}, last_ovf, exp_o);
        $display("case %s: data=%0d ovf=%0d", name, last_data, last_ovf);
    endtask

    initial begin
        int base_results;
        aclr      = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        bias      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        aclr = 1'b0;
        tick();

        // Basic window with single-cycle out_valid pulse
        valid_cycles = 0;
        run_case("basic", 256, 0, 9, 0);
        check("basic_valid_cycles", longint'(valid_cycles), 1);

        run_case("sat_pos", 256, 64'sh7FFF0000, 32767, 1);
        run_case("sat_neg", 256, -64'sd2147483648, -32768, 1);
`ifdef CONV_ACCUM_RELU_EN
        run_case("neg", -512, 0, 0, 0);
        run_case("floor_neg", -1, 0, 0, 0);
`else
        run_case("neg", -512, 0, -18, 0);
        run_case("floor_neg", -1, 0, -1, 0);
`endif
        run_case("floor_pos", 1, 0, 0, 0);
        run_case("bias_only", 0, 5000, 19, 0);

        // Two windows back to back with no gap on the input side
        base_results = n_results;
        send_window(100, 1280, 2 * TAPS);
        drain();
        check("b2b_results", longint'(n_results - base_results), 2);
        check("b2b_data", last_data, 8);
        $display("case b2b: results=%0d data=%0d", n_results - base_results, last_data);

        // Mixed-sign taps with a bias; model alone supplies the expectation
        for (int i = 0; i < TAPS; i++) send_tap((i % 2 == 0) ? 3000 + i : -1700 - 3 * i, 12345);
        in_valid = 1'b0;
        drain();
        $display("case mixed: data=%0d ovf=%0d", last_data, last_ovf);

        // Backpressure: first result held while the next window fills
        base_results = n_results;
        out_ready = 1'b0;
        for (int i = 0; i < 2 * TAPS - 1; i++) send_tap(256, 0);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("bp_in_ready_low", longint'(in_ready), 0);
            check("bp_held_valid", longint'(out_valid), 1);
            check("bp_held_data", longint'(out_data), 9);
            tick();
        end
        out_ready = 1'b1;
        send_tap(256, 0);
        in_valid = 1'b0;
        drain();
        check("bp_results", longint'(n_results - base_results), 2);
        check("bp_second_data", last_data, 9);
        $display("case backpressure: results=%0d data=%0d", n_results - base_results, last_data);

        // Two-cycle reset mid-stream with a tap presented throughout
        for (int i = 0; i < 3; i++) send_tap(700, 0);
        aclr = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check("rst_in_ready", longint'(in_ready), 0);
            tick();
        end
        aclr     = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", longint'(in_ready), 1);
        check("post_rst_valid", longint'(out_valid), 0);
        tick();
        $display("case reset2: busy=%0d", busy);

        // One-cycle reset after four taps, then a clean window
        for (int i = 0; i < 4; i++) send_tap(3000, 64'sh10000000);
        in_valid = 1'b0;
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        run_case("rst_mid", 256, 0, 9, 0);

        // Reset discards a result waiting downstream
        out_ready = 1'b0;
        send_window(256, 0, TAPS);
        tick();
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("rst_drop_valid", longint'(out_valid), 0);
        tick();
        $display("case reset_drop: out_valid=%0d", out_valid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
